// File: rtl/serial_rx8_pkg.sv
// Shared definitions for the framed serial receiver: FSM state encoding and
// the default frame width.
package serial_rx8_pkg;

    localparam int RX_WIDTH_DEF = 8;

    // Encoding 2'd3 is never entered on purpose; the FSM treats it as a fault.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2,
        ST_BAD  = 2'd3
    } rx_state_t;

    // Width of a counter that must reach n-1 without wrapping.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_rx8.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits, stop bit,
// sampled on external strobes; good frames produce data plus a one-cycle load.
module serial_rx8
    import serial_rx8_pkg::*;
#(
    parameter int WIDTH     = RX_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_en,
    input  logic             sin,
    output logic [WIDTH-1:0] data,
    output logic             load,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    rx_state_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;

    // Where the new sample enters depends on the bit order of the link.
    always_comb begin
        shreg_next = shreg;
        if (MSB_FIRST) begin
            shreg_next = {shreg[WIDTH-2:0], sin};
        end else begin
            shreg_next = {sin, shreg[WIDTH-1:1]};
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            data      <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bit_en && !sin) begin
                        state     <= ST_DATA;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        frame_err <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (bit_en) begin
                        shreg <= shreg_next;
                        // Saturate at the last data bit instead of wrapping.
                        if (cnt == CNT_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_en) begin
                        if (sin) begin
                            data <= shreg;
                            load <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
